// File: rtl/level_crossing_counter.sv
// rtl/level_crossing_counter.sv - hysteresis level-crossing counter; optional debounce via CROSS_DEBOUNCE_EN
module level_crossing_counter #(
    parameter int DATA_W   = 10,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1,
    parameter int DEB_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in,
    input  logic [DATA_W-1:0] th_hi,
    input  logic [DATA_W-1:0] th_lo,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic [CNT_W-1:0]  count,
    output logic              cross_pulse,
    output logic              above,
    output logic              ovf
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_BELOW = 2'd1,
        S_ABOVE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic rise_q;
    logic fall_q;
    logic deb_done;
    logic rise_ev;
    logic fall_ev;
    logic count_ev;

    // Comparisons are strict so a sample equal to a threshold never moves the FSM.
    assign rise_q = (in > th_hi);
    assign fall_q = (in < th_lo);

`ifdef CROSS_DEBOUNCE_EN
    logic [3:0] run_cnt;
    logic       pend_q;

    assign pend_q   = ((state == S_BELOW) && rise_q) || ((state == S_ABOVE) && fall_q);
    assign deb_done = (run_cnt == 4'(DEB_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= 4'd0;
        end else if (in_valid) begin
            if (state == S_INIT) begin
                run_cnt <= 4'd0;
            end else if (pend_q) begin
                // The qualifying sample that completes the run also changes state.
                run_cnt <= deb_done ? 4'd0 : run_cnt + 4'd1;
            end else begin
                run_cnt <= 4'd0;
            end
        end
    end
`else
    logic unused_deb_len;

    assign unused_deb_len = (DEB_LEN > 0);
    assign deb_done       = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rise_ev    = 1'b0;
        fall_ev    = 1'b0;
        if (in_valid) begin
            case (state)
                S_INIT: begin
                    state_next = rise_q ? S_ABOVE : S_BELOW;
                end
                S_BELOW: begin
                    if (rise_q && deb_done) begin
                        state_next = S_ABOVE;
                        rise_ev    = 1'b1;
                    end
                end
                S_ABOVE: begin
                    if (fall_q && deb_done) begin
                        state_next = S_BELOW;
                        fall_ev    = 1'b1;
                    end
                end
                default: begin
                    state_next = S_INIT;
                end
            endcase
        end
    end

    assign count_ev = (rise_ev && mode[0]) || (fall_ev && mode[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            cross_pulse <= 1'b0;
            ovf         <= 1'b0;
        end else if (clear) begin
            // Clear wins over a same-cycle event; the FSM still follows the sample.
            count       <= '0;
            cross_pulse <= 1'b0;
            ovf         <= 1'b0;
        end else if (count_ev) begin
            cross_pulse <= 1'b1;
            if (count == {CNT_W{1'b1}}) begin
                ovf <= 1'b1;
                if (!SATURATE) begin
                    count <= '0;
                end
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            cross_pulse <= 1'b0;
        end
    end

    assign above = (state == S_ABOVE);

endmodule

// File: tb/tb_level_crossing_counter.sv
// tb/tb_level_crossing_counter.sv - directed self-checking bench for level_crossing_counter
module tb_level_crossing_counter;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] th_hi;
    logic [DATA_W-1:0] th_lo;
    logic [1:0]        mode;
    logic              clear;

    logic [CNT_W-1:0]  count;
    logic              cross_pulse;
    logic              above;
    logic              ovf;
    logic [CNT_W-1:0]  count_w;
    logic              cross_pulse_w;
    logic              above_w;
    logic              ovf_w;

    int n_checks;
    int n_fail;
    int pulses;

    level_crossing_counter #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .SATURATE(1'b1), .DEB_LEN(3)
    ) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
        .th_hi(th_hi), .th_lo(th_lo), .mode(mode), .clear(clear),
        .count(count), .cross_pulse(cross_pulse), .above(above), .ovf(ovf)
    );

    level_crossing_counter #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .SATURATE(1'b0), .DEB_LEN(3)
    ) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
        .th_hi(th_hi), .th_lo(th_lo), .mode(mode), .clear(clear),
        .count(count_w), .cross_pulse(cross_pulse_w), .above(above_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input logic v, input int val);
        in_valid = v;
        in       = DATA_W'(val);
        @(posedge clk);
        #1;
        if (cross_pulse) pulses++;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pulses = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 4'd0 || cross_pulse !== 1'b0 || above !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d pulse=%b above=%b ovf=%b, expected 0 0 0 0",
                     count, cross_pulse, above, ovf);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        do_reset();
        th_hi = 10'd80; th_lo = 10'd60; mode = 2'b01;
        step(1, 0);
        step(1, 100);
        n_checks++;
        if (count !== 4'd1 || cross_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first_rise: count=%0d pulse=%b, expected 1 1", count, cross_pulse);
        end
        step(1, 70);
        step(1, 100);
        step(0, 50);
        n_checks++;
        if (above !== 1'b1 || cross_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_invalid_hold: above=%b pulse=%b, expected 1 0", above, cross_pulse);
        end
        step(1, 50);
        n_checks++;
        if (above !== 1'b0 || count !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_fall_uncounted: above=%b count=%0d, expected 0 1", above, count);
        end
        step(1, 100);
        step(0, 0);
        n_checks++;
        if (count !== 4'd2 || pulses != 2 || above !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_final: count=%0d pulses=%0d above=%b, expected 2 2 1",
                     count, pulses, above);
        end
    endtask

    task automatic test_both();
        do_reset();
        th_hi = 10'd80; th_lo = 10'd80; mode = 2'b11;
        step(1, 0);
        step(1, 81);
        step(1, 80);
        n_checks++;
        if (count !== 4'd1 || cross_pulse !== 1'b0 || above !== 1'b1) begin
            n_fail++;
            $display("FAIL both_equal_ignored: count=%0d pulse=%b above=%b, expected 1 0 1",
                     count, cross_pulse, above);
        end
        step(1, 79);
        step(1, 81);
        n_checks++;
        if (count !== 4'd3 || pulses != 3) begin
            n_fail++;
            $display("FAIL both_final: count=%0d pulses=%0d, expected 3 3", count, pulses);
        end
    endtask

    task automatic test_mode_off();
        do_reset();
        th_hi = 10'd80; th_lo = 10'd60; mode = 2'b00;
        step(1, 0);
        step(1, 100);
        n_checks++;
        if (count !== 4'd0 || above !== 1'b1 || cross_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_off: count=%0d above=%b pulse=%b, expected 0 1 0",
                     count, above, cross_pulse);
        end
        mode = 2'b10;
        step(1, 10);
        n_checks++;
        if (count !== 4'd1 || above !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_falling: count=%0d above=%b, expected 1 0", count, above);
        end
    endtask

    task automatic test_saturate_wrap();
        do_reset();
        th_hi = 10'd80; th_lo = 10'd60; mode = 2'b01;
        step(1, 0);
        for (int i = 0; i < 15; i++) begin
            step(1, 100);
            step(1, 50);
        end
        n_checks++;
        if (count !== 4'd15 || count_w !== 4'd15 || ovf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL preload15: sat=%0d wrap=%0d ovf_w=%b, expected 15 15 0",
                     count, count_w, ovf_w);
        end
        step(1, 100);
        n_checks++;
        if (count !== 4'd15 || ovf !== 1'b1 || cross_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: count=%0d ovf=%b pulse=%b, expected 15 1 1",
                     count, ovf, cross_pulse);
        end
        n_checks++;
        if (count_w !== 4'd0 || ovf_w !== 1'b1 || cross_pulse_w !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: count=%0d ovf=%b pulse=%b, expected 0 1 1",
                     count_w, ovf_w, cross_pulse_w);
        end
        clear = 1'b1;
        step(0, 0);
        clear = 1'b0;
        n_checks++;
        if (ovf !== 1'b0 || ovf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ovf: ovf=%b ovf_w=%b, expected 0 0", ovf, ovf_w);
        end
    endtask

    task automatic test_clear_priority();
        do_reset();
        th_hi = 10'd80; th_lo = 10'd60; mode = 2'b01;
        step(1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 100);
            step(1, 50);
        end
        n_checks++;
        if (count !== 4'd5) begin
            n_fail++;
            $display("FAIL clear_preload: count=%0d, expected 5", count);
        end
        clear = 1'b1;
        step(1, 100);
        clear = 1'b0;
        n_checks++;
        if (count !== 4'd0 || cross_pulse !== 1'b0 || above !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_priority: count=%0d pulse=%b above=%b, expected 0 0 1",
                     count, cross_pulse, above);
        end
        step(1, 50);
        step(1, 100);
        n_checks++;
        if (count !== 4'd1) begin
            n_fail++;
            $display("FAIL clear_after: count=%0d, expected 1", count);
        end
    endtask

    task automatic test_reset_init();
        do_reset();
        th_hi = 10'd80; th_lo = 10'd60; mode = 2'b01;
        step(1, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 100);
            if (i < 8) step(1, 50);
        end
        n_checks++;
        if (count !== 4'd9 || above !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload: count=%0d above=%b, expected 9 1", count, above);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 4'd0 || above !== 1'b0 || cross_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: count=%0d above=%b pulse=%b, expected 0 0 0",
                     count, above, cross_pulse);
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 1000);
        n_checks++;
        if (count !== 4'd0 || above !== 1'b1 || cross_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init_sample: count=%0d above=%b pulse=%b, expected 0 1 0",
                     count, above, cross_pulse);
        end
    endtask

`ifdef CROSS_DEBOUNCE_EN
    task automatic test_debounce();
        do_reset();
        th_hi = 10'd80; th_lo = 10'd60; mode = 2'b01;
        step(1, 0);
        step(1, 100);
        step(0, 0);
        step(1, 100);
        step(1, 0);
        step(1, 100);
        step(0, 0);
        step(1, 100);
        step(0, 0);
        n_checks++;
        if (count !== 4'd0 || above !== 1'b0 || pulses != 0) begin
            n_fail++;
            $display("FAIL debounce_pending: count=%0d above=%b pulses=%0d, expected 0 0 0",
                     count, above, pulses);
        end
        step(1, 100);
        n_checks++;
        if (count !== 4'd1 || above !== 1'b1 || cross_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL debounce_fire: count=%0d above=%b pulse=%b, expected 1 1 1",
                     count, above, cross_pulse);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in       = '0;
        th_hi    = 10'd80;
        th_lo    = 10'd60;
        mode     = 2'b00;
        clear    = 1'b0;
        test_reset();
        test_basic();
        test_both();
        test_mode_off();
        test_saturate_wrap();
        test_clear_priority();
        test_reset_init();
`ifdef CROSS_DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
